// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Architectural integer register file. It sits at the consuming end of the
//   writeback interface, commits the MEM/WB write triple, and serves two
//   decode-stage read ports plus one debug read port.
//
//   The storage array has no reset, so it can map onto distributed RAM. After
//   reset, a clear sequencer writes zero to registers 1..NUM_REGS-1. It holds
//   init_stall high until the last register has been cleared. Register 0 is
//   hard-wired to zero on every read path, so it never needs clearing.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   wb_we      writeback write enable
//   wb_waddr   writeback destination register
//   wb_wdata   writeback data
//   rd1_en     read port 1 enable
//   rd1_addr   read port 1 address
//   rd1_data   read port 1 data (combinational, WB bypass)
//   rd2_en     read port 2 enable
//   rd2_addr   read port 2 address
//   rd2_data   read port 2 data (combinational, WB bypass)
//   dbg_addr   debug read address
//   dbg_data   debug read data (combinational, no bypass)
//   init_stall pipeline stall request, high while clearing
//   wb_count   number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int NUM_REGS       = 32,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              init_stall,
    output logic [31:0]       wb_count
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic   CLR_EN    = (CLEAR_ON_RESET != 0);
    localparam state_t RST_STATE = CLR_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              init_stall_q, init_stall_d;
    logic [31:0]       wb_count_q, wb_count_d;

    // Non-reset storage; the write port is shared between the clear
    // sequencer and the writeback commit.
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        init_stall_d = init_stall_q;
        wb_count_d   = wb_count_q;
        mem_we       = 1'b0;
        mem_waddr    = wb_waddr;
        mem_wdata    = wb_wdata;
        case (state_q)
            ST_INIT: begin
                // Writeback is ignored here; the sequencer owns the write port.
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d      = ST_RUN;
                    init_stall_d = 1'b0;
                end
            end
            default: begin
                if (wb_we && (wb_waddr != '0)) begin
                    mem_we     = 1'b1;
                    wb_count_d = wb_count_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RST_STATE;
            clr_idx_q    <= ADDR_W'(1);
            init_stall_q <= CLR_EN;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            init_stall_q <= init_stall_d;
            wb_count_q   <= wb_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read muxes. While clearing, the array is only partly zeroed, so every
    // port returns 0. The bypass compare cannot match address 0 because of
    // the earlier check on the read address.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        dbg_data = '0;
        if (state_q == ST_RUN) begin
            if (rd1_en && (rd1_addr != '0)) begin
                rd1_data = (wb_we && (wb_waddr == rd1_addr)) ? wb_wdata : regs_q[rd1_addr];
            end
            if (rd2_en && (rd2_addr != '0)) begin
                rd2_data = (wb_we && (wb_waddr == rd2_addr)) ? wb_wdata : regs_q[rd2_addr];
            end
            if (dbg_addr != '0) begin
                dbg_data = regs_q[dbg_addr];
            end
        end
    end

    assign init_stall = init_stall_q;
    assign wb_count   = wb_count_q;

endmodule
